// File: rtl/mul_err_monitor_if.sv
// Sample stream into the error monitor: one (approximate, exact) product
// pair per accepted valid/ready transfer.
interface mul_err_monitor_if #(
    parameter int OUT_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] appr;
    logic [OUT_WIDTH-1:0] exact;

    modport master (output in_valid, output appr, output exact, input in_ready);
    modport slave  (input in_valid, input appr, input exact, output in_ready);
endinterface

// File: rtl/mul_err_monitor.sv
// Error-statistics monitor for the approximate multiplier datapath.
// Accepts a programmed number of (appr, exact) pairs, scales both by an
// arithmetic right shift, and accumulates signed error, absolute error,
// absolute result, peak error and exact-match counts. The run ends with a
// flush of the one-stage pipeline, after which results are held with done=1.
module mul_err_monitor #(
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 8,
    parameter int CNT_WIDTH   = 24,
    parameter int ACC_WIDTH   = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [CNT_WIDTH-1:0]        num_samples,
    mul_err_monitor_if.slave            s_if,
    output logic                        busy,
    output logic                        done,
    output logic signed [ACC_WIDTH-1:0] err_sum,
    output logic [ACC_WIDTH-1:0]        abs_err_sum,
    output logic [ACC_WIDTH-1:0]        abs_res_sum,
    output logic [OUT_WIDTH:0]          max_abs_err,
    output logic [CNT_WIDTH-1:0]        same_cnt,
    output logic [CNT_WIDTH-1:0]        sample_cnt
);
    // One extra bit makes the difference of two scaled products and the
    // magnitude of the most-negative product exact.
    localparam int EW = OUT_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic                   clear_stats;
    logic                   accept;

    logic signed [OUT_WIDTH-1:0] appr_s, exact_s;
    logic [EW-1:0]          err_w, abs_err_w, abs_res_w, exact_x;

    logic                   vld_p1_q, vld_p1_d;
    logic [EW-1:0]          err_p1_q, err_p1_d;
    logic [EW-1:0]          abs_err_p1_q, abs_err_p1_d;
    logic [EW-1:0]          abs_res_p1_q, abs_res_p1_d;

    logic [ACC_WIDTH-1:0]   err_sum_q, err_sum_d;
    logic [ACC_WIDTH-1:0]   abs_err_sum_q, abs_err_sum_d;
    logic [ACC_WIDTH-1:0]   abs_res_sum_q, abs_res_sum_d;
    logic [EW-1:0]          max_abs_err_q, max_abs_err_d;
    logic [CNT_WIDTH-1:0]   same_cnt_q, same_cnt_d;
    logic [CNT_WIDTH-1:0]   sample_cnt_q, sample_cnt_d;

    assign s_if.in_ready = (state_q == RUN);
    assign accept        = s_if.in_valid & (state_q == RUN);
    assign busy          = (state_q == RUN) | (state_q == FLUSH);
    assign done          = (state_q == DONE);
    assign err_sum       = err_sum_q;
    assign abs_err_sum   = abs_err_sum_q;
    assign abs_res_sum   = abs_res_sum_q;
    assign max_abs_err   = max_abs_err_q;
    assign same_cnt      = same_cnt_q;
    assign sample_cnt    = sample_cnt_q;

    // Run control: start handling, remaining-sample count, flush wait.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        clear_stats = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    clear_stats = 1'b1;
                    if (num_samples != '0) begin
                        state_d     = RUN;
                        remaining_d = num_samples;
                    end else begin
                        state_d     = DONE;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    remaining_d = remaining_q - CNT_WIDTH'(1);
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!vld_p1_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scaling, signed error and magnitudes of the incoming pair.
    always_comb begin
        appr_s    = $signed(s_if.appr) >>> SHIFT_WIDTH;
        exact_s   = $signed(s_if.exact) >>> SHIFT_WIDTH;
        exact_x   = {exact_s[OUT_WIDTH-1], exact_s};
        err_w     = {appr_s[OUT_WIDTH-1], appr_s} - exact_x;
        abs_err_w = err_w[EW-1] ? (~err_w + EW'(1)) : err_w;
        abs_res_w = exact_x[EW-1] ? (~exact_x + EW'(1)) : exact_x;
    end

    // Stage-1 capture: load the per-sample terms only on an accepted transfer.
    always_comb begin
        vld_p1_d     = accept;
        err_p1_d     = err_p1_q;
        abs_err_p1_d = abs_err_p1_q;
        abs_res_p1_d = abs_res_p1_q;
        if (accept) begin
            err_p1_d     = err_w;
            abs_err_p1_d = abs_err_w;
            abs_res_p1_d = abs_res_w;
        end
    end

    // Stage-2 accumulation; a new run clears everything first.
    always_comb begin
        err_sum_d     = err_sum_q;
        abs_err_sum_d = abs_err_sum_q;
        abs_res_sum_d = abs_res_sum_q;
        max_abs_err_d = max_abs_err_q;
        same_cnt_d    = same_cnt_q;
        sample_cnt_d  = sample_cnt_q;
        if (clear_stats) begin
            err_sum_d     = '0;
            abs_err_sum_d = '0;
            abs_res_sum_d = '0;
            max_abs_err_d = '0;
            same_cnt_d    = '0;
            sample_cnt_d  = '0;
        end else if (vld_p1_q) begin
            err_sum_d     = err_sum_q + {{(ACC_WIDTH-EW){err_p1_q[EW-1]}}, err_p1_q};
            abs_err_sum_d = abs_err_sum_q + ACC_WIDTH'(abs_err_p1_q);
            abs_res_sum_d = abs_res_sum_q + ACC_WIDTH'(abs_res_p1_q);
            sample_cnt_d  = sample_cnt_q + CNT_WIDTH'(1);
            if (err_p1_q == '0) begin
                same_cnt_d = same_cnt_q + CNT_WIDTH'(1);
            end
            if (abs_err_p1_q > max_abs_err_q) begin
                max_abs_err_d = abs_err_p1_q;
            end
        end
    end

    // State register and remaining-sample counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Stage-1 pipeline register; reset discards any in-flight sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q     <= 1'b0;
            err_p1_q     <= '0;
            abs_err_p1_q <= '0;
            abs_res_p1_q <= '0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            err_p1_q     <= err_p1_d;
            abs_err_p1_q <= abs_err_p1_d;
            abs_res_p1_q <= abs_res_p1_d;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sum_q     <= '0;
            abs_err_sum_q <= '0;
            abs_res_sum_q <= '0;
            max_abs_err_q <= '0;
            same_cnt_q    <= '0;
            sample_cnt_q  <= '0;
        end else begin
            err_sum_q     <= err_sum_d;
            abs_err_sum_q <= abs_err_sum_d;
            abs_res_sum_q <= abs_res_sum_d;
            max_abs_err_q <= max_abs_err_d;
            same_cnt_q    <= same_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
        end
    end
endmodule

// File: tb/tb_mul_err_monitor.sv
// Testbench for mul_err_monitor: directed vector table, handshake/reset/restart
// sequences and randomized runs against an integer-arithmetic reference model.
module tb_mul_err_monitor;
    localparam int OW = 32;
    localparam int SH = 8;
    localparam int CW = 24;
    localparam int AW = 64;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_samples;
    logic          busy;
    logic          done;
    logic signed [AW-1:0] err_sum;
    logic [AW-1:0] abs_err_sum;
    logic [AW-1:0] abs_res_sum;
    logic [OW:0]   max_abs_err;
    logic [CW-1:0] same_cnt;
    logic [CW-1:0] sample_cnt;

    mul_err_monitor_if #(.OUT_WIDTH(OW)) sif ();

    mul_err_monitor #(
        .OUT_WIDTH(OW), .SHIFT_WIDTH(SH), .CNT_WIDTH(CW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .s_if(sif), .busy(busy), .done(done), .err_sum(err_sum),
        .abs_err_sum(abs_err_sum), .abs_res_sum(abs_res_sum),
        .max_abs_err(max_abs_err), .same_cnt(same_cnt), .sample_cnt(sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: statistics of the samples accepted in this run.
    longint m_err, m_abs_err, m_abs_res, m_max;
    int     m_same, m_cnt;

    logic [31:0] da [0:63];
    logic [31:0] de [0:63];
    bit          vpat [0:7];

    typedef struct packed {
        logic [23:0]      n;
        logic [3:0][31:0] a;
        logic [3:0][31:0] e;
        logic [63:0]      x_err;
        logic [63:0]      x_abs_err;
        logic [63:0]      x_abs_res;
        logic [63:0]      x_max;
        logic [23:0]      x_same;
    } vec_t;

    vec_t tbl [0:3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic void m_clear();
        m_err = 0; m_abs_err = 0; m_abs_res = 0; m_max = 0; m_same = 0; m_cnt = 0;
    endfunction

    function automatic void model_add(input logic [31:0] a, input logic [31:0] e);
        longint as, es, d, ad;
        as = longint'($signed(a)) >>> SH;
        es = longint'($signed(e)) >>> SH;
        d  = as - es;
        ad = (d < 0) ? -d : d;
        m_err     += d;
        m_abs_err += ad;
        m_abs_res += (es < 0) ? -es : es;
        if (d == 0) m_same++;
        m_cnt++;
        if (ad > m_max) m_max = ad;
    endfunction

    task automatic check_stats(input string tag);
        chk({tag, "_err_sum"},     err_sum,          m_err);
        chk({tag, "_abs_err_sum"}, abs_err_sum,      m_abs_err);
        chk({tag, "_abs_res_sum"}, abs_res_sum,      m_abs_res);
        chk({tag, "_max_abs_err"}, 64'(max_abs_err), m_max);
        chk({tag, "_same_cnt"},    64'(same_cnt),    64'(m_same));
        chk({tag, "_sample_cnt"},  64'(sample_cnt),  64'(m_cnt));
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start(input int n);
        start = 1'b1;
        num_samples = CW'(n);
        m_clear();
        @(negedge clk);
        start = 1'b0;
        chk("start_busy",    64'(busy),          64'(n != 0));
        chk("start_done",    64'(done),          64'(n == 0));
        chk("start_ready",   64'(sif.in_ready),  64'(n != 0));
        chk("start_cnt_clr", 64'(sample_cnt),    64'd0);
        chk("start_err_clr", err_sum,            64'd0);
        chk("start_max_clr", 64'(max_abs_err),   64'd0);
    endtask

    // mode: 0 always valid, 1 random valid, 2 valid from vpat.
    task automatic run(input int n, input int mode, input bit trail, input bit mid_start);
        int idx;
        int cyc;
        bit v;
        do_start(n);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: v = vpat[cyc % 8];
            endcase
            sif.in_valid = v;
            sif.appr     = da[idx];
            sif.exact    = de[idx];
            if (mid_start && cyc == 1) begin
                start = 1'b1;
                num_samples = 24'd1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (v && sif.in_ready) begin
                model_add(da[idx], de[idx]);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        sif.in_valid = trail;
        chk("accept_count", 64'(idx), 64'(n));
        chk("flush_busy",  64'(busy),         64'd1);
        chk("flush_done",  64'(done),         64'd0);
        chk("flush_ready", 64'(sif.in_ready), 64'd0);
        @(negedge clk);
        chk("flush2_done", 64'(done), 64'd0);
        @(negedge clk);
        sif.in_valid = 1'b0;
        chk("done_set",  64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        check_stats("run");
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        num_samples = '0;
        sif.in_valid = 1'b0;
        sif.appr = '0;
        sif.exact = '0;
        m_clear();

        // Directed vector table.
        tbl[0].n = 24'd4;
        for (int j = 0; j < 4; j++) begin
            tbl[0].a[j] = 32'h0001_2345;
            tbl[0].e[j] = 32'h0001_2345;
        end
        tbl[0].x_err = 64'd0; tbl[0].x_abs_err = 64'd0; tbl[0].x_abs_res = 64'd1164;
        tbl[0].x_max = 64'd0; tbl[0].x_same = 24'd4;

        tbl[1] = '0;
        tbl[1].n = 24'd2;
        tbl[1].a[0] = 32'h0000_0300; tbl[1].e[0] = 32'h0000_0100;
        tbl[1].a[1] = 32'hFFFF_FF00; tbl[1].e[1] = 32'h0000_0200;
        tbl[1].x_err = 64'hFFFF_FFFF_FFFF_FFFF; tbl[1].x_abs_err = 64'd5;
        tbl[1].x_abs_res = 64'd3; tbl[1].x_max = 64'd3; tbl[1].x_same = 24'd0;

        tbl[2] = '0;
        tbl[2].n = 24'd1;
        tbl[2].a[0] = 32'h7FFF_FF00; tbl[2].e[0] = 32'h8000_0000;
        tbl[2].x_err = 64'd16777215; tbl[2].x_abs_err = 64'd16777215;
        tbl[2].x_abs_res = 64'd8388608; tbl[2].x_max = 64'd16777215; tbl[2].x_same = 24'd0;

        tbl[3] = '0;
        tbl[3].n = 24'd3;
        tbl[3].a[0] = 32'h8000_0000; tbl[3].e[0] = 32'h7FFF_FFFF;
        tbl[3].a[1] = 32'h0000_0100; tbl[3].e[1] = 32'h0000_00FF;
        tbl[3].a[2] = 32'hFFFF_FFFF; tbl[3].e[2] = 32'h0000_0000;
        tbl[3].x_err = -64'sd16777215; tbl[3].x_abs_err = 64'd16777217;
        tbl[3].x_abs_res = 64'd8388607; tbl[3].x_max = 64'd16777215; tbl[3].x_same = 24'd0;

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(sif.in_ready), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        check_stats("rst");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                da[j] = tbl[i].a[j];
                de[j] = tbl[i].e[j];
            end
            run(int'(tbl[i].n), 0, 1'b0, 1'b0);
            chk("tbl_err_sum",     err_sum,           tbl[i].x_err);
            chk("tbl_abs_err_sum", abs_err_sum,       tbl[i].x_abs_err);
            chk("tbl_abs_res_sum", abs_res_sum,       tbl[i].x_abs_res);
            chk("tbl_max_abs_err", 64'(max_abs_err),  tbl[i].x_max);
            chk("tbl_same_cnt",    64'(same_cnt),     64'(tbl[i].x_same));
            chk("tbl_sample_cnt",  64'(sample_cnt),   64'(tbl[i].n));
        end

        // Zero-sample run: straight to DONE, later valids ignored.
        do_start(0);
        check_stats("zero");
        sif.in_valid = 1'b1;
        sif.appr = 32'h1234_5678;
        sif.exact = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("zero_ready", 64'(sif.in_ready), 64'd0);
        end
        sif.in_valid = 1'b0;
        chk("zero_cnt", 64'(sample_cnt), 64'd0);
        chk("zero_done_hold", 64'(done), 64'd1);

        // Handshake with gapped valid and a trailing valid during flush.
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 1; vpat[3] = 0;
        vpat[4] = 1; vpat[5] = 1; vpat[6] = 1; vpat[7] = 1;
        da[0] = 32'h0000_0500; de[0] = 32'h0000_0100;
        da[1] = 32'h0000_0200; de[1] = 32'h0000_0200;
        da[2] = 32'hFFFF_F000; de[2] = 32'h0000_1000;
        run(3, 2, 1'b1, 1'b0);
        chk("hs_sample_cnt", 64'(sample_cnt), 64'd3);

        // Restart from DONE, with a start pulse during RUN that must be ignored.
        for (int j = 0; j < 4; j++) begin
            da[j] = 32'h0000_0700 + 32'(j << 8);
            de[j] = 32'h0000_0100;
        end
        run(4, 0, 1'b0, 1'b1);
        chk("restart_cnt", 64'(sample_cnt), 64'd4);

        // Reset in the middle of a run.
        do_start(5);
        for (int k = 0; k < 2; k++) begin
            sif.in_valid = 1'b1;
            sif.appr = 32'h0000_0500;
            sif.exact = 32'h0000_0100;
            @(negedge clk);
        end
        sif.in_valid = 1'b0;
        chk("mid_cnt_pre", 64'(sample_cnt), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy",  64'(busy), 64'd0);
        chk("mrst_done",  64'(done), 64'd0);
        chk("mrst_ready", 64'(sif.in_ready), 64'd0);
        m_clear();
        check_stats("mrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        da[0] = 32'h0004_4400; de[0] = 32'h0004_4400;
        da[1] = 32'h0004_4400; de[1] = 32'h0004_4400;
        run(2, 0, 1'b0, 1'b0);
        chk("mrst_fresh_cnt",  64'(sample_cnt), 64'd2);
        chk("mrst_fresh_same", 64'(same_cnt),   64'd2);

        // Randomized runs against the reference model.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 40);
            for (int j = 0; j < n; j++) begin
                case ($urandom_range(0, 3))
                    0: begin da[j] = $urandom; de[j] = $urandom; end
                    1: begin de[j] = $urandom; da[j] = de[j]; end
                    2: begin
                        de[j] = $urandom;
                        da[j] = de[j] + 32'($urandom_range(0, 2047)) - 32'd1024;
                    end
                    default: begin
                        case ($urandom_range(0, 4))
                            0: da[j] = 32'h8000_0000;
                            1: da[j] = 32'h7FFF_FFFF;
                            2: da[j] = 32'h0;
                            3: da[j] = 32'hFFFF_FFFF;
                            default: da[j] = 32'h0000_0100;
                        endcase
                        de[j] = (j % 2 == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    end
                endcase
            end
            run(n, 1, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_err_monitor.md
# mul_err_monitor

Hardware error-statistics monitor for the approximate multiplier datapath. It consumes a stream of (approximate, exact) product pairs through a valid/ready handshake and applies the same fixed-point scaling used at the multiplier output. It accumulates error and result statistics over a programmed number of samples, then presents them with a held `done` flag. It sits at the receiving end of the multiplier under evaluation, so mean, variance-free error magnitude and error-rate figures can be measured on-chip rather than in simulation only.

## Interface
- `OUT_WIDTH`, 32, width of raw signed products on `appr`/`exact`
- `SHIFT_WIDTH`, 8, arithmetic right shift applied to both products (fixed-point scaling)
- `CNT_WIDTH`, 24, width of sample counters and `num_samples`
- `ACC_WIDTH`, 64, width of all sum accumulators
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a run; sampled in IDLE or DONE only
- `num_samples`  in  CNT_WIDTH  samples per run, captured on accepted `start`
- `in_valid`  in  1  sample pair present
- `in_ready`  out  1  monitor accepts a sample this cycle
- `appr`  in  OUT_WIDTH  signed approximate product
- `exact`  in  OUT_WIDTH  signed precise product
- `busy`  out  1  state is RUN or FLUSH
- `done`  out  1  statistics valid, held in DONE
- `err_sum`  out  ACC_WIDTH  signed sum of (appr_s - exact_s)
- `abs_err_sum`  out  ACC_WIDTH  sum of |appr_s - exact_s|
- `abs_res_sum`  out  ACC_WIDTH  sum of |exact_s|
- `max_abs_err`  out  OUT_WIDTH+1  largest |error| seen
- `same_cnt`  out  CNT_WIDTH  samples with zero error
- `sample_cnt`  out  CNT_WIDTH  samples accumulated

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE + `start`:
  - If `num_samples` != 0: go to RUN, clear all statistics, load remaining = `num_samples`.
  - If `num_samples` == 0: go to DONE with statistics cleared.
- `start` is ignored in RUN and FLUSH.
- RUN: `in_ready`=1. A sample is accepted when `in_valid & in_ready`. Remaining decrements per accept. The accept that makes remaining 0 moves the FSM to FLUSH.
- FLUSH: `in_ready`=0. Wait until the pipeline is empty, then go to DONE.
- DONE: `done`=1. Statistics held until the next accepted `start` or reset.
- `in_ready`=0 in IDLE, FLUSH and DONE. `in_valid` in those states is ignored and nothing is counted.
- Stage 1 (registered on accept):
  - appr_s = appr >>> SHIFT_WIDTH and exact_s = exact >>> SHIFT_WIDTH, both sign-extended.
  - err = appr_s - exact_s in OUT_WIDTH+1 bits signed, which never overflows.
  - |err| and |exact_s| are computed in OUT_WIDTH+1 bits unsigned, so the most-negative input is exact.
- Stage 2 (stage-1 valid):
  - `err_sum` += sign-extended err.
  - `abs_err_sum` += |err|.
  - `abs_res_sum` += |exact_s|.
  - `same_cnt` += (err==0).
  - `sample_cnt` += 1.
  - `max_abs_err` updates when |err| > current value (strict).
- Accumulators wrap modulo 2^ACC_WIDTH. Defaults cannot overflow for 2^CNT_WIDTH-1 samples.

## Timing
- Reset values: state IDLE, `in_ready`=0, `busy`=0, `done`=0, all statistics 0, pipeline valids 0.
- Reset mid-run: asynchronous return to the reset values. Any in-flight samples are discarded.
- `busy` rises on the edge that accepts `start`. `in_ready` is 1 from the next cycle.
- Latency: a sample accepted at edge t is in stage 1 after t and in the accumulators after edge t+1.
- Final accept at edge t:
  - FLUSH after t.
  - DONE with `done`=1 and `busy`=0 after edge t+2.
  - Statistics are final whenever `done`=1.
- `num_samples`==0 with `start`: `done`=1 after the same edge, all statistics 0.
- Throughput: one sample per cycle in RUN.
- `start` in DONE: `done` drops and statistics clear on that edge.

## Test plan
- Exact match: SHIFT_WIDTH=8, num_samples=4, appr=exact=0x00012345 each cycle -> `err_sum`=0, `abs_err_sum`=0, `same_cnt`=4, `sample_cnt`=4, `abs_res_sum`=4*0x123=1164, `done` 2 edges after 4th accept.
- Signed scaling: num_samples=2, pairs (0x00000300, 0x00000100) then (0xFFFFFF00, 0x00000200) -> `err_sum`=-1, `abs_err_sum`=5, `max_abs_err`=3, `abs_res_sum`=3, `same_cnt`=0.
- Extremes: num_samples=1, appr=0x7FFFFF00, exact=0x80000000 -> err=+16777215, `abs_res_sum`=8388608, no wrap.
- Zero count and handshake: start with num_samples=0 -> `done`=1 next cycle, stats 0. Then num_samples=3 with `in_valid` toggling 1,0,1,0,1,1 -> exactly 3 samples counted; `in_ready`=0 during FLUSH, so the trailing valid is not counted.
- Reset mid-run: num_samples=5, assert `rst_n`=0 after 2 accepts -> all outputs 0 immediately. A fresh run of 2 identical pairs then gives `sample_cnt`=2, `same_cnt`=2.
- Restart from DONE: `start` while `done`=1 -> `done`=0 and stats cleared on that edge; `start` pulsed during RUN has no effect on the count.
